// File: rtl/ble_cmd_pkg.sv
// ble_cmd_pkg: shared types and constants for the BLE command decoder.
//   state_t      : packet assembly FSM states
//   CMD_*        : command byte values
//   PAN_*        : pan direction codes carried in P_LO[1:0]
package ble_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_PHI  = 3'd2,
    S_PLO  = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  localparam logic [7:0] CMD_SWING   = 8'h01;
  localparam logic [7:0] CMD_PAN     = 8'h02;
  localparam logic [7:0] CMD_NEWGAME = 8'h03;

  localparam logic [1:0] PAN_STOP  = 2'b00;
  localparam logic [1:0] PAN_LEFT  = 2'b01;
  localparam logic [1:0] PAN_RIGHT = 2'b10;

endpackage

// File: rtl/ble_cmd_decoder_sat_counter8.sv
// sat_counter8: 8-bit counter that increments on inc_in and holds at 255.
// Ports:
//   clk_in    : clock
//   rst_in    : synchronous active-low clear
//   inc_in    : increment request for this cycle
//   count_out : current count (registered)
module sat_counter8 (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       inc_in,
  output logic [7:0] count_out
);

  logic [7:0] count_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count_q <= 8'd0;
    end else if (inc_in && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/ble_cmd_decoder.sv
// ble_cmd_decoder: assembles 5-byte BLE command packets (SYNC, CMD, P_HI,
// P_LO, CSUM), checks CSUM = CMD ^ P_HI ^ P_LO and turns valid packets into
// gameplay controls. Also keeps saturating packet / error counts.
// Ports:
//   clk_in, rst_in          : clock, synchronous active-low reset
//   byte_in, byte_valid_in  : received byte and its one-cycle strobe
//   swing_valid_out         : one-cycle pulse per valid swing packet
//   swing_power_out         : payload of last valid swing packet
//   pan_left_out/right_out  : camera pan levels (mutually exclusive)
//   new_game_out            : one-cycle pulse per valid new-game packet
//   pkt_count_out           : valid packets, saturating
//   err_count_out           : rejected packets + timeouts, saturating
//   state_dbg_out           : current FSM state for observation
//
// Handshake: byte_valid_in is a one-cycle strobe with no ready; every strobed
// byte is consumed in the cycle it is presented (no backpressure, no buffer).
module ble_cmd_decoder
  import ble_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [15:0] BYTE_TIMEOUT = 16'd65535,
  parameter logic [31:0] PAN_WATCHDOG = 32'd37125000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic        swing_valid_out,
  output logic [15:0] swing_power_out,
  output logic        pan_left_out,
  output logic        pan_right_out,
  output logic        new_game_out,
  output logic [7:0]  pkt_count_out,
  output logic [7:0]  err_count_out,
  output state_t      state_dbg_out
);

  state_t      state_q;
  logic [7:0]  cmd_q;
  logic [7:0]  phi_q;
  logic [7:0]  plo_q;
  logic [15:0] timer_q;
  logic [31:0] wd_q;
  logic        swing_valid_q;
  logic [15:0] swing_power_q;
  logic        pan_left_q;
  logic        pan_right_q;
  logic        new_game_q;

  logic        csum_strobe;
  logic        csum_ok;
  logic        cmd_known;
  logic        pkt_good;
  logic        pkt_bad;
  logic        timeout_hit;

  assign csum_strobe = byte_valid_in && (state_q == S_CSUM);
  assign csum_ok     = (byte_in == (cmd_q ^ phi_q ^ plo_q));

  // Pan code 11 is the only malformed payload among known commands.
  always_comb begin
    cmd_known = 1'b0;
    case (cmd_q)
      CMD_SWING:   cmd_known = 1'b1;
      CMD_PAN:     cmd_known = (plo_q[1:0] != 2'b11);
      CMD_NEWGAME: cmd_known = 1'b1;
      default:     cmd_known = 1'b0;
    endcase
  end

  assign pkt_good = csum_strobe && csum_ok && cmd_known;
  assign pkt_bad  = csum_strobe && !pkt_good;

  // Expiry is the cycle whose closing edge would bring the idle count to
  // BYTE_TIMEOUT; a byte strobed in that same cycle takes precedence.
  assign timeout_hit = (state_q != S_IDLE) && !byte_valid_in &&
                       (timer_q == BYTE_TIMEOUT - 16'd1);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= S_IDLE;
      cmd_q         <= 8'd0;
      phi_q         <= 8'd0;
      plo_q         <= 8'd0;
      timer_q       <= 16'd0;
      wd_q          <= 32'd0;
      swing_valid_q <= 1'b0;
      swing_power_q <= 16'd0;
      pan_left_q    <= 1'b0;
      pan_right_q   <= 1'b0;
      new_game_q    <= 1'b0;
    end else begin
      swing_valid_q <= 1'b0;
      new_game_q    <= 1'b0;

      // Pan watchdog: levels drop on the edge where the count runs out.
      if (pan_left_q || pan_right_q) begin
        if (wd_q <= 32'd1) begin
          pan_left_q  <= 1'b0;
          pan_right_q <= 1'b0;
          wd_q        <= 32'd0;
        end else begin
          wd_q <= wd_q - 32'd1;
        end
      end

      // Inter-byte timer only runs while a packet is partially received.
      if (state_q == S_IDLE || byte_valid_in) begin
        timer_q <= 16'd0;
      end else if (timeout_hit) begin
        timer_q <= 16'd0;
        state_q <= S_IDLE;
      end else begin
        timer_q <= timer_q + 16'd1;
      end

      // SYNC_BYTE seen after S_IDLE is plain data: no resynchronisation.
      if (byte_valid_in) begin
        case (state_q)
          S_IDLE: if (byte_in == SYNC_BYTE) state_q <= S_CMD;
          S_CMD: begin
            cmd_q   <= byte_in;
            state_q <= S_PHI;
          end
          S_PHI: begin
            phi_q   <= byte_in;
            state_q <= S_PLO;
          end
          S_PLO: begin
            plo_q   <= byte_in;
            state_q <= S_CSUM;
          end
          S_CSUM:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end

      // Dispatch is placed after the watchdog so a pan command landing in
      // the expiry cycle overrides the clear.
      if (pkt_good) begin
        case (cmd_q)
          CMD_SWING: begin
            swing_power_q <= {phi_q, plo_q};
            swing_valid_q <= 1'b1;
          end
          CMD_PAN: begin
            case (plo_q[1:0])
              PAN_LEFT: begin
                pan_left_q  <= 1'b1;
                pan_right_q <= 1'b0;
                wd_q        <= PAN_WATCHDOG;
              end
              PAN_RIGHT: begin
                pan_left_q  <= 1'b0;
                pan_right_q <= 1'b1;
                wd_q        <= PAN_WATCHDOG;
              end
              PAN_STOP: begin
                pan_left_q  <= 1'b0;
                pan_right_q <= 1'b0;
                wd_q        <= 32'd0;
              end
              default: begin
                pan_left_q  <= 1'b0;
                pan_right_q <= 1'b0;
                wd_q        <= 32'd0;
              end
            endcase
          end
          CMD_NEWGAME: begin
            new_game_q  <= 1'b1;
            pan_left_q  <= 1'b0;
            pan_right_q <= 1'b0;
            wd_q        <= 32'd0;
          end
          default: ;
        endcase
      end
    end
  end

  sat_counter8 u_pkt_count (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .inc_in    (pkt_good),
    .count_out (pkt_count_out)
  );

  // Timeouts only fire with no byte present, so they never coincide with a
  // rejected packet and a single increment per cycle suffices.
  sat_counter8 u_err_count (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .inc_in    (pkt_bad || timeout_hit),
    .count_out (err_count_out)
  );

  assign swing_valid_out = swing_valid_q;
  assign swing_power_out = swing_power_q;
  assign pan_left_out    = pan_left_q;
  assign pan_right_out   = pan_right_q;
  assign new_game_out    = new_game_q;
  assign state_dbg_out   = state_q;

endmodule
